// File: rtl/gray_pkg.sv
// Shared definitions for the Gray code monitor: state encoding and
// Gray/binary conversion helpers usable from both RTL and benches.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Binary is the XOR of the code with all of its right shifts; upper bits
  // beyond width must be zero on entry.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < width; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Parameterised combinational Gray-to-binary decoder.
module gray2bin_dec
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  always_comb begin
    binary = WIDTH'(gray2bin(32'(gray), WIDTH));
  end

endmodule

// File: rtl/gray_monitor.sv
// Gray code consumer: decodes incoming samples, checks that each accepted
// code holds or advances by one, counts wraps and latches protocol faults.
module gray_monitor
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Binary,
  output logic             Locked,
  output logic             WrapPulse,
  output logic [CNT_W-1:0] Wraps,
  output logic             Error
);

  state_t           state, state_n;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] bin_n;
  logic             locked_n;
  logic             pulse_n;
  logic [CNT_W-1:0] wraps_n;
  logic             err_n;

  gray2bin_dec #(.WIDTH(WIDTH)) u_dec (
    .gray   (Gray),
    .binary (dec)
  );

  assign bin_inc = Binary + WIDTH'(1);

  always_comb begin
    state_n  = state;
    bin_n    = Binary;
    locked_n = Locked;
    pulse_n  = 1'b0;
    wraps_n  = Wraps;
    err_n    = Error;
    case (state)
      IDLE: begin
        if (En) begin
          bin_n    = dec;
          locked_n = 1'b1;
          state_n  = TRACK;
        end
      end
      TRACK: begin
        if (En && dec != Binary) begin
          if (dec == bin_inc) begin
            bin_n = dec;
            // A +1 step out of all-ones is exactly the wrap to zero.
            if (Binary == '1) begin
              pulse_n = 1'b1;
              if (Wraps != '1) wraps_n = Wraps + CNT_W'(1);
            end
          end else begin
            err_n    = 1'b1;
            locked_n = 1'b0;
            state_n  = FAULT;
          end
        end
      end
      FAULT: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Binary    <= '0;
      Locked    <= 1'b0;
      WrapPulse <= 1'b0;
      Wraps     <= '0;
      Error     <= 1'b0;
    end else begin
      state     <= state_n;
      Binary    <= bin_n;
      Locked    <= locked_n;
      WrapPulse <= pulse_n;
      Wraps     <= wraps_n;
      Error     <= err_n;
    end
  end

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor; a second instance with a 2-bit wrap
// counter shares the stimulus to exercise saturation.
module tb_gray_monitor;
  import gray_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       En;
  logic [2:0] Gray;

  logic [2:0] Binary, Binary2;
  logic       Locked, Locked2;
  logic       WrapPulse, WrapPulse2;
  logic [7:0] Wraps;
  logic [1:0] Wraps2;
  logic       Error, Error2;

  int checks = 0;
  int errors = 0;

  logic [2:0] codes [8];

  always #5 Clk = ~Clk;

  gray_monitor #(.WIDTH(3), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray),
    .Binary(Binary), .Locked(Locked), .WrapPulse(WrapPulse),
    .Wraps(Wraps), .Error(Error)
  );

  gray_monitor #(.WIDTH(3), .CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray),
    .Binary(Binary2), .Locked(Locked2), .WrapPulse(WrapPulse2),
    .Wraps(Wraps2), .Error(Error2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [2:0] g);
    Reset = r;
    En    = en;
    Gray  = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] b, input logic l,
                         input logic p, input logic [7:0] w, input logic e);
    chk({tag, ".bin"}, 32'(Binary), 32'(b));
    chk({tag, ".lock"}, 32'(Locked), 32'(l));
    chk({tag, ".pulse"}, 32'(WrapPulse), 32'(p));
    chk({tag, ".wraps"}, 32'(Wraps), 32'(w));
    chk({tag, ".err"}, 32'(Error), 32'(e));
  endtask

  initial begin
    codes = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    Reset = 1'b1; En = 1'b0; Gray = 3'b000;

    // 1: reset, then a full ascending sequence
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b0, 3'b000);
    chk_all("reset", 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("reset.state", 32'(dut.state), 32'(IDLE));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, codes[k]);
      chk_all($sformatf("seq%0d", k), 3'(k), 1'b1, 1'b0, 8'd0, 1'b0);
    end

    // 2: wrap, then three more full cycles; dut2 saturates at 3
    step(1'b0, 1'b1, 3'b000);
    chk_all("wrap1", 3'd0, 1'b1, 1'b1, 8'd1, 1'b0);
    chk("wrap1.w2", 32'(Wraps2), 32'd1);
    step(1'b0, 1'b1, 3'b001);
    chk_all("after_wrap1", 3'd1, 1'b1, 1'b0, 8'd1, 1'b0);
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 2; k < 8; k++) step(1'b0, 1'b1, codes[k]);
      step(1'b0, 1'b1, 3'b000);
      chk_all($sformatf("wrap%0d", rep + 2), 3'd0, 1'b1, 1'b1, 8'(rep + 2), 1'b0);
      chk($sformatf("wrap%0d.w2", rep + 2), 32'(Wraps2), (rep + 2 > 3) ? 32'd3 : 32'(rep + 2));
      chk($sformatf("wrap%0d.p2", rep + 2), 32'(WrapPulse2), 32'd1);
      if (rep < 2) step(1'b0, 1'b1, 3'b001);
    end
    chk("sat.bin2", 32'(Binary2), 32'd0);
    chk("sat.lock2", 32'(Locked2), 32'd1);
    chk("sat.err2", 32'(Error2), 32'd0);
    step(1'b0, 1'b1, 3'b001);
    chk("sat.pulse2_clr", 32'(WrapPulse2), 32'd0);
    chk("sat.w2_hold", 32'(Wraps2), 32'd3);

    // 3: stall and disabled sampling
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b011);
    chk_all("lock011", 3'd2, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 3'b011);
      chk_all($sformatf("stall%0d", k), 3'd2, 1'b1, 1'b0, 8'd0, 1'b0);
    end
    step(1'b0, 1'b0, 3'b110);
    chk_all("en_off", 3'd2, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 3'b010);
    chk_all("resume", 3'd3, 1'b1, 1'b0, 8'd0, 1'b0);

    // 4: skip fault, absorbing, reset recovery
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b001);
    chk_all("lock001", 3'd1, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 3'b010);
    chk_all("skip", 3'd1, 1'b0, 1'b0, 8'd0, 1'b1);
    chk("skip.state", 32'(dut.state), 32'(FAULT));
    step(1'b0, 1'b1, 3'b011);
    chk_all("fault_hold1", 3'd1, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b1, 3'b001);
    chk_all("fault_hold2", 3'd1, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b1, 3'b011);
    chk_all("fault_reset", 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("fault_reset.state", 32'(dut.state), 32'(IDLE));
    step(1'b0, 1'b1, 3'b110);
    chk_all("relock", 3'd4, 1'b1, 1'b0, 8'd0, 1'b0);

    // 6: reset wins over a would-be wrap
    step(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, codes[k]);
    chk_all("at7", 3'd7, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 3'b000);
    chk_all("rst_vs_wrap", 3'd0, 1'b0, 1'b0, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_monitor.md
Name: gray_monitor

Overview:
- Receiving end of the 3-bit Gray counter interface: samples an incoming Gray code each enabled cycle and decodes it to binary.
- Checks that the code sequence is legal: each sample either holds the previous value or advances by exactly +1 modulo 2^WIDTH.
- Counts wrap-arounds and flags protocol faults.
- Sits downstream of the Gray counter, e.g. behind a clock-domain or board-level link, as its consumer and checker.

Parameters:
- WIDTH, 3, Gray/binary code width.
- CNT_W, 8, width of the wrap counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  sample strobe; Gray is sampled on rising Clk when En=1.
- Gray  input  WIDTH  incoming Gray code.
- Binary  output  WIDTH  decoded value of last accepted sample (registered).
- Locked  output  1  high once a first sample has been accepted and no fault seen.
- WrapPulse  output  1  one-cycle pulse when an accepted step goes from binary max to 0.
- Wraps  output  CNT_W  count of wrap events, saturating.
- Error  output  1  sticky fault flag.

Behaviour:
- Reset is synchronous and active-high. Reset=1 at a rising edge gives:
  - Binary=0, Locked=0, WrapPulse=0, Wraps=0, Error=0, state=IDLE.
  - Reset has priority over En in the same cycle.
  - Reset mid-stream discards all history.
- Decode, combinational: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i down to 0. Let D = decode(Gray).
- State machine: IDLE, TRACK, FAULT.
- IDLE:
  - En=0: stay.
  - En=1: Binary<=D, Locked<=1, go TRACK. Any first code is accepted. No wrap is counted on the first sample.
- TRACK, En=0: hold all outputs; WrapPulse<=0.
- TRACK, En=1, D==Binary: hold state (legal stall); WrapPulse<=0.
- TRACK, En=1, D==Binary+1 mod 2^WIDTH: Binary<=D.
  - If Binary was all-ones and D==0: WrapPulse<=1 for exactly one cycle, and Wraps<=Wraps+1.
  - Wraps saturates at 2^CNT_W-1; WrapPulse still fires when saturated.
- TRACK, En=1, any other D (skip, backward step, multi-bit change): Error<=1, Locked<=0, go FAULT. Binary holds the last good value.
- FAULT: absorbing.
  - Ignores En and Gray.
  - Outputs frozen except WrapPulse=0.
  - Only Reset exits, to IDLE.
- Latency: outputs reflect a sample one cycle after the sampling edge. WrapPulse is registered with the same timing.
- Width rules: +1 comparison done in WIDTH bits so max+1 wraps to 0. Wraps arithmetic in CNT_W bits with saturation check before increment.

Decomposition:
- Shared package gray_pkg:
  - constant default width 3.
  - function gray2bin(WIDTH).
  - function bin2gray, for bench reuse.
  - state encoding constants IDLE=2'd0, TRACK=2'd1, FAULT=2'd2.
- One natural sub-module: gray2bin_dec, a parameterised combinational decoder instantiated once.
- Control FSM and counters stay in gray_monitor.

Test Plan:
1. Reset=1 two cycles, then En=1 with Gray 000,001,011,010,110,111,101,100 on consecutive cycles -> Binary 0..7 each one cycle after its sample; Locked=1 from cycle after first sample; Error=0.
2. Continue from 100 with Gray=000 -> Binary=0, WrapPulse=1 for one cycle, Wraps=1. Run 3 more full cycles -> Wraps=4.
3. Lock on 011, then Gray=011 for 5 cycles with En=1, then En=0 with Gray=110 -> Binary stays 2, no Error. Then En=1, Gray=010 -> Binary=3.
4. Lock on 001 (Binary=1), then Gray=010 (decode 3, a skip) -> Error=1, Locked=0, Binary=1. Further legal codes -> no change. Reset=1 -> all outputs 0, state IDLE.
5. CNT_W=2: force 4 wraps -> Wraps stays 3 after fourth wrap, WrapPulse still pulses.
6. Reset asserted in the same cycle as En=1 with Gray=000 after Binary=7 -> no WrapPulse, Wraps=0, Binary=0, Locked=0.
